// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding and the active-low seven-segment digit table.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low
    localparam logic [6:0] SEG7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        return SEG7[d];
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration:
// shift the next dividend bit into the partial remainder, subtract B if it fits.
module seq_divider_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] bx;

    // One extra bit so neither the shifted remainder nor B is truncated
    assign t  = {rem_i, quo_i[WIDTH-1]};
    assign bx = {1'b0, b_i};

    always_comb begin
        rem_o = t[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (t >= bx) begin
            rem_o = WIDTH'(t - bx);
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, Start/Done handshake.
// Define SEQ_DIVIDER_HEX_EN to add the HEX seven-segment output port.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               Busy,
    output logic               Done,
`ifdef SEQ_DIVIDER_HEX_EN
    output logic               DivZero,
    output logic [7*WIDTH-1:0] HEX
`else
    output logic               DivZero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .b_i   (b_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    b_d  = B;
                    q_d  = '0;
                    r_d  = '0;
                    dz_d = 1'b0;
                    if (B == '0) begin
                        // Divide-by-zero resolves immediately
                        state_d = ST_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CW'(WIDTH);
                        rem_d   = '0;
                        quo_d   = A;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    q_d     = quo_nx;
                    r_d     = rem_nx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;
    assign Busy    = (state_q == ST_RUN);
    assign Done    = (state_q == ST_DONE);

`ifdef SEQ_DIVIDER_HEX_EN
    logic [WIDTH-1:0] a_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_q <= '0;
        end else if (Start && state_q != ST_RUN) begin
            a_q <= A;
        end
    end

    assign HEX = {seg7(q_q), seg7(r_q), seg7(a_q), seg7(b_q)};
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results,
// a negedge monitor pops and checks them whenever Done pulses.
module tb_seq_divider;

    localparam int W = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Busy;
    logic         Done;
    logic         DivZero;
`ifdef SEQ_DIVIDER_HEX_EN
    logic [7*W-1:0] HEX;
`endif

    seq_divider #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Q       (Q),
        .R       (R),
        .Busy    (Busy),
        .Done    (Done),
`ifdef SEQ_DIVIDER_HEX_EN
        .DivZero (DivZero),
        .HEX     (HEX)
`else
        .DivZero (DivZero)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

`ifdef SEQ_DIVIDER_HEX_EN
    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
`endif

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", int'(Q), e.q);
                chk("r", int'(R), e.r);
                chk("divzero", int'(DivZero), e.dz);
                chk("latency", cyc, e.cyc);
                chk("busy_in_done", int'(Busy), 0);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 2 * W + 8 && sb.size() != 0; i++) @(negedge Clock);
        if (sb.size() != 0) begin
            chk("timeout", int'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic do_div(input int a, input int b,
                          input int eq, input int er, input int ed);
        exp_t e;
        @(negedge Clock);
        Start = 1'b1;
        A = W'(a);
        B = W'(b);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        e.q = eq; e.r = er; e.dz = ed;
        e.cyc = cyc + ((b == 0) ? 0 : W);
        sb.push_back(e);
        wait_drain();
        @(negedge Clock);
        chk("held_q", int'(Q), eq);
        chk("held_r", int'(R), er);
        chk("idle_busy", int'(Busy), 0);
`ifdef SEQ_DIVIDER_HEX_EN
        chk("hex", int'(HEX), int'({seg_ref[eq], seg_ref[er],
                                    seg_ref[a], seg_ref[b]}));
`endif
    endtask

    initial begin
        exp_t e;
        int c0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_q", int'(Q), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_dz", int'(DivZero), 0);
`ifdef SEQ_DIVIDER_HEX_EN
        chk("rst_hex", int'(HEX), int'({4{7'h40}}));
`endif
        Reset = 1'b0;

        do_div(13, 3, 4, 1, 0);
        do_div(15, 1, 15, 0, 0);
        do_div(2, 9, 0, 2, 0);
        do_div(7, 0, 15, 7, 1);
        do_div(15, 15, 1, 0, 0);
        do_div(14, 15, 0, 14, 0);

        // Start held high: ignored while busy, accepted in the DONE cycle
        @(negedge Clock);
        Start = 1'b1; A = 4'd13; B = 4'd3;
        @(posedge Clock);
        #1;
        c0 = cyc;
        e.q = 4; e.r = 1; e.dz = 0; e.cyc = c0 + W;
        sb.push_back(e);
        e.q = 1; e.r = 0; e.dz = 0; e.cyc = c0 + 2 * W + 1;
        sb.push_back(e);
        @(negedge Clock);
        chk("run_q_cleared", int'(Q), 0);
        @(negedge Clock);
        A = 4'd1; B = 4'd1;
        chk("busy_in_run", int'(Busy), 1);
        while (cyc < c0 + W + 1) @(negedge Clock);
        chk("b2b_busy", int'(Busy), 1);
        chk("b2b_q_cleared", int'(Q), 0);
        chk("b2b_r_cleared", int'(R), 0);
        Start = 1'b0;
        wait_drain();

        // Reset in the second RUN cycle aborts without a Done
        @(negedge Clock);
        Start = 1'b1; A = 4'd13; B = 4'd3;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_q", int'(Q), 0);
        chk("abort_r", int'(R), 0);
        chk("abort_done", int'(Done), 0);
        repeat (2 * W) @(negedge Clock);

        // Reset wins over a simultaneous Start
        Start = 1'b1; Reset = 1'b1; A = 4'd9; B = 4'd2;
        @(negedge Clock);
        Start = 1'b0; Reset = 1'b0;
        chk("rst_start_busy", int'(Busy), 0);
        chk("rst_start_done", int'(Done), 0);
        repeat (2 * W) @(negedge Clock);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) do_div(a, b, 15, a, 1);
                else        do_div(a, b, a / b, a % b, 0);
            end
        end

        repeat (4) @(negedge Clock);
        chk("sb_empty", int'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
